// File: rtl/mcp_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mcp_core
// Brief   : three-port instruction queue executing one op per cycle, in fixed
//           priority, on a shared 16x8 register file and 256x8 data memory.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module mcp_core #(
  parameter int NREGS     = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start1,
  input  logic        start2,
  input  logic        start3,
  input  logic [27:0] inst1,
  input  logic [27:0] inst2,
  input  logic [27:0] inst3,
  output logic        done,
  output logic [7:0]  reg_out,
  output logic [7:0]  mem_out
);

  localparam logic [3:0] c_OP_ADD   = 4'h1;
  localparam logic [3:0] c_OP_SUB   = 4'h2;
  localparam logic [3:0] c_OP_AND   = 4'h3;
  localparam logic [3:0] c_OP_OR    = 4'h4;
  localparam logic [3:0] c_OP_XOR   = 4'h5;
  localparam logic [3:0] c_OP_ADDI  = 4'h6;
  localparam logic [3:0] c_OP_MOVI  = 4'h7;
  localparam logic [3:0] c_OP_LOAD  = 4'h8;
  localparam logic [3:0] c_OP_STORE = 4'h9;

  logic [7:0]  r_regs [NREGS];
  logic [7:0]  r_mem  [MEM_DEPTH];
  logic [27:0] r_inst [3];
  logic [2:0]  r_pend;
  logic        r_done;
  logic [7:0]  r_reg_out;
  logic [7:0]  r_mem_out;

  logic [2:0]  w_start;
  logic [27:0] w_inst_in [3];
  logic [2:0]  w_exec_oh;
  logic        w_exec;
  logic [27:0] w_cur;
  logic [3:0]  w_op, w_rd, w_rs1, w_rs2;
  logic [7:0]  w_imm, w_a, w_b, w_ld;
  logic        w_reg_we, w_mem_we, w_mem_hit;
  logic [7:0]  w_reg_val, w_mem_val;
  logic [2:0]  w_cap, w_pend_nxt;
  logic        w_unused;

  assign w_start      = {start3, start2, start1};
  assign w_inst_in[0] = inst1;
  assign w_inst_in[1] = inst2;
  assign w_inst_in[2] = inst3;

  // Lowest pending slot wins: isolate the least-significant set bit.
  assign w_exec_oh = r_pend & ~(r_pend - 3'd1);
  assign w_exec    = |r_pend;

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_exec_oh[i]) w_cur = r_inst[i];
    end
  end

  assign w_op     = w_cur[27:24];
  assign w_rd     = w_cur[23:20];
  assign w_rs1    = w_cur[19:16];
  assign w_rs2    = w_cur[15:12];
  assign w_imm    = w_cur[11:4];
  assign w_unused = ^w_cur[3:0];
  assign w_a      = r_regs[w_rs1];
  assign w_b      = r_regs[w_rs2];
  assign w_ld     = r_mem[w_imm];

  always_comb begin
    w_reg_we  = 1'b0;
    w_reg_val = '0;
    w_mem_we  = 1'b0;
    w_mem_hit = 1'b0;
    w_mem_val = '0;
    if (w_exec) begin
      case (w_op)
        c_OP_ADD:   begin w_reg_we = 1'b1; w_reg_val = w_a + w_b; end
        c_OP_SUB:   begin w_reg_we = 1'b1; w_reg_val = w_a - w_b; end
        c_OP_AND:   begin w_reg_we = 1'b1; w_reg_val = w_a & w_b; end
        c_OP_OR:    begin w_reg_we = 1'b1; w_reg_val = w_a | w_b; end
        c_OP_XOR:   begin w_reg_we = 1'b1; w_reg_val = w_a ^ w_b; end
        c_OP_ADDI:  begin w_reg_we = 1'b1; w_reg_val = w_a + w_imm; end
        c_OP_MOVI:  begin w_reg_we = 1'b1; w_reg_val = w_imm; end
        c_OP_LOAD:  begin
          w_reg_we  = 1'b1;
          w_reg_val = w_ld;
          w_mem_hit = 1'b1;
          w_mem_val = w_ld;
        end
        c_OP_STORE: begin
          w_mem_we  = 1'b1;
          w_mem_hit = 1'b1;
          w_mem_val = w_a;
        end
        default: ;
      endcase
    end
  end

  // A slot being drained this edge may be refilled at the same edge.
  assign w_cap      = w_start & (~r_pend | w_exec_oh);
  assign w_pend_nxt = w_cap | (r_pend & ~w_exec_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)     r_regs[i] <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i]  <= '0;
      for (int i = 0; i < 3; i++)         r_inst[i] <= '0;
      r_pend    <= '0;
      r_done    <= 1'b0;
      r_reg_out <= '0;
      r_mem_out <= '0;
    end else begin
      if (w_reg_we) r_regs[w_rd] <= w_reg_val;
      if (w_mem_we) r_mem[w_imm] <= w_mem_val;
      for (int i = 0; i < 3; i++) begin
        if (w_cap[i]) r_inst[i] <= w_inst_in[i];
      end
      r_pend <= w_pend_nxt;
      r_done <= w_exec && (w_pend_nxt == 3'b000);
      if (w_reg_we)  r_reg_out <= w_reg_val;
      if (w_mem_hit) r_mem_out <= w_mem_val;
    end
  end

  assign done    = r_done;
  assign reg_out = r_reg_out;
  assign mem_out = r_mem_out;

endmodule
`default_nettype wire

// File: tb/tb_mcp_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_mcp_core
// Brief   : directed + randomized bench for mcp_core against a queue model.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_mcp_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [27:0] inst1 = '0, inst2 = '0, inst3 = '0;
  logic        done;
  logic [7:0]  reg_out, mem_out;

  int checks = 0;
  int failures = 0;

  mcp_core #(.NREGS(16), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .start1(start1), .start2(start2), .start3(start3),
    .inst1(inst1), .inst2(inst2), .inst3(inst3),
    .done(done), .reg_out(reg_out), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state plus one queued instruction per port.
  logic [7:0]  m_regs [16];
  logic [7:0]  m_mem  [256];
  logic [27:0] m_slot [3];
  bit          m_pend [3];
  logic        m_done;
  logic [7:0]  m_reg_out, m_mem_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int imm);
    logic [27:0] v;
    v = {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[7:0], 4'h0};
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++)  m_regs[i] = '0;
    for (int i = 0; i < 256; i++) m_mem[i]  = '0;
    for (int i = 0; i < 3; i++) begin m_slot[i] = '0; m_pend[i] = 0; end
    m_done = 0; m_reg_out = '0; m_mem_out = '0;
  endfunction

  function automatic void model_exec(input logic [27:0] in);
    int op, rd, a, b, imm;
    op = in[27:24]; rd = in[23:20];
    a = m_regs[in[19:16]]; b = m_regs[in[15:12]]; imm = in[11:4];
    case (op)
      1: begin m_regs[rd] = 8'((a + b) % 256);       m_reg_out = m_regs[rd]; end
      2: begin m_regs[rd] = 8'((a - b + 256) % 256); m_reg_out = m_regs[rd]; end
      3: begin m_regs[rd] = 8'(a & b);               m_reg_out = m_regs[rd]; end
      4: begin m_regs[rd] = 8'(a | b);               m_reg_out = m_regs[rd]; end
      5: begin m_regs[rd] = 8'(a ^ b);               m_reg_out = m_regs[rd]; end
      6: begin m_regs[rd] = 8'((a + imm) % 256);     m_reg_out = m_regs[rd]; end
      7: begin m_regs[rd] = 8'(imm);                 m_reg_out = m_regs[rd]; end
      8: begin m_regs[rd] = m_mem[imm]; m_reg_out = m_regs[rd]; m_mem_out = m_mem[imm]; end
      9: begin m_mem[imm] = 8'(a); m_mem_out = 8'(a); end
      default: ;
    endcase
  endfunction

  function automatic void model_step(input logic [2:0] st, input logic [27:0] a,
                                     input logic [27:0] b, input logic [27:0] c);
    int sel = -1;
    bool_any: begin end
    for (int i = 0; i < 3; i++) if (m_pend[i] && sel < 0) sel = i;
    if (sel >= 0) begin
      model_exec(m_slot[sel]);
      m_pend[sel] = 0;
    end
    if (st[0] && !m_pend[0]) begin m_slot[0] = a; m_pend[0] = 1; end
    if (st[1] && !m_pend[1]) begin m_slot[1] = b; m_pend[1] = 1; end
    if (st[2] && !m_pend[2]) begin m_slot[2] = c; m_pend[2] = 1; end
    m_done = (sel >= 0) && !m_pend[0] && !m_pend[1] && !m_pend[2];
  endfunction

  task automatic cycle(input logic [2:0] st, input logic [27:0] a,
                       input logic [27:0] b, input logic [27:0] c);
    @(negedge clk);
    start1 = st[0]; start2 = st[1]; start3 = st[2];
    inst1 = a; inst2 = b; inst3 = c;
    model_step(st, a, b, c);
    @(posedge clk);
    #1;
    chk("done", done, m_done);
    chk("reg_out", reg_out, m_reg_out);
    chk("mem_out", mem_out, m_mem_out);
    start1 = 0; start2 = 0; start3 = 0;
  endtask

  task automatic idle();
    cycle(3'b000, '0, '0, '0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_done", done, 0);
    chk("rst_reg_out", reg_out, 0);
    chk("rst_mem_out", mem_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0]  st;
    logic [27:0] ins [3];
    model_reset();
    #12 rst_n = 1'b1;

    // Single op
    cycle(3'b001, mk(7, 3, 0, 0, 8'h25), '0, '0);
    chk("single_idle_done", done, 0);
    idle();
    chk("single_reg", reg_out, 8'h25);
    chk("single_done", done, 1);
    idle();
    chk("single_done_drop", done, 0);

    // Priority and sequencing with wraparound
    cycle(3'b111, mk(7, 1, 0, 0, 200), mk(6, 2, 1, 0, 100), mk(2, 4, 2, 1, 0));
    idle(); chk("prio1", reg_out, 200); chk("prio1_done", done, 0);
    idle(); chk("prio2", reg_out, 44);  chk("prio2_done", done, 0);
    idle(); chk("prio3", reg_out, 100); chk("prio3_done", done, 1);
    idle(); chk("prio_done_drop", done, 0);

    // Memory round trip
    cycle(3'b001, mk(7, 1, 0, 0, 8'h5A), '0, '0);
    cycle(3'b001, mk(9, 0, 1, 0, 8'h80), '0, '0);
    cycle(3'b001, mk(8, 7, 0, 0, 8'h80), '0, '0);
    chk("store_mem", mem_out, 8'h5A);
    idle();
    chk("load_mem", mem_out, 8'h5A);
    chk("load_reg", reg_out, 8'h5A);

    // Busy slot: second start3 must be dropped
    cycle(3'b111, mk(7, 1, 0, 0, 1), mk(7, 2, 0, 0, 2), mk(7, 5, 0, 0, 8'h11));
    cycle(3'b100, '0, '0, mk(7, 5, 0, 0, 8'h22));
    idle(); idle();
    chk("busy_slot", reg_out, 8'h11);
    chk("busy_done", done, 1);
    idle();
    chk("busy_no_second", reg_out, 8'h11);

    // Reset then LOAD sees cleared memory
    do_reset();
    cycle(3'b001, mk(8, 6, 0, 0, 8'h80), '0, '0);
    idle();
    chk("post_rst_load", mem_out, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      st = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        int op = $urandom_range(0, 15);
        int imm = (op == 8 || op == 9) ? 8'h80 + $urandom_range(0, 3) : $urandom_range(0, 255);
        ins[k] = mk(op, $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), imm);
      end
      cycle(st, ins[0], ins[1], ins[2]);
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    repeat (4) idle();

    // Reset after first execution discards remaining work
    cycle(3'b111, mk(7, 1, 0, 0, 8'h31), mk(7, 2, 0, 0, 8'h32), mk(7, 3, 0, 0, 8'h33));
    idle();
    chk("midrst_first", reg_out, 8'h31);
    do_reset();
    for (int n = 0; n < 4; n++) begin
      idle();
      chk("midrst_done", done, 0);
      chk("midrst_reg", reg_out, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcp_core.md
Name: mcp_core

Overview:
- Three-port instruction-execution core for the mcp multi-port test environment.
- Three independent requesters each present a 28-bit instruction with a start strobe.
- The core queues at most one instruction per port and executes them one per cycle in fixed priority against a shared 16x8 register file and a 256x8 data memory.
- `done` signals that all accepted work has drained. `reg_out` and `mem_out` expose the last results for observation.

Parameters:
- NREGS, 16, register-file depth (4-bit register index).
- MEM_DEPTH, 256, data-memory depth (8-bit address).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start1  input  1  capture strobe for port 1
- start2  input  1  capture strobe for port 2
- start3  input  1  capture strobe for port 3
- inst1  input  28  instruction for port 1
- inst2  input  28  instruction for port 2
- inst3  input  28  instruction for port 3
- done  output  1  one-cycle pulse: all pending work completed
- reg_out  output  8  value of last register write
- mem_out  output  8  data of last LOAD or STORE

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - all registers, memory, pending flags, slot instructions, done, reg_out and mem_out = 0.
  - Reset mid-operation discards all pending instructions, and no done is produced for them.
- Instruction format:
  - [27:24] opcode, [23:20] rd, [19:16] rs1, [15:12] rs2, [11:4] imm8/addr, [3:0] ignored.
- Opcodes (8-bit arithmetic, results modulo 256):
  - 0 NOP
  - 1 ADD rd=rs1+rs2
  - 2 SUB rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI rd=rs1+imm
  - 7 MOVI rd=imm
  - 8 LOAD rd=mem[imm]
  - 9 STORE mem[imm]=rs1
  - A-F behave as NOP but still complete.
- All 16 registers are general purpose; r0 is not hardwired.
- Capture:
  - At a rising edge with startN=1, if slot N is not pending, or is being executed at that same edge, instN is latched into slot N and pendingN is set.
  - If slot N is pending and not being executed at that edge, startN is ignored and the old instruction is kept.
- Execute:
  - At each rising edge where any slot was pending before the edge, the lowest-numbered pending slot executes (priority 1 > 2 > 3). Its result is written at that edge and its pending flag clears, unless a same-edge recapture applies.
  - Exactly one instruction executes per cycle.
- Latency: an instruction captured at edge N executes at edge N+1 at the earliest.
- Ordering: instructions execute strictly sequentially, so each one observes all earlier writes. No forwarding hazards exist.
- reg_out is updated to the written value on ops 1-8. mem_out is updated to the memory data on LOAD (read value) and STORE (written value). Other ops leave both unchanged.
- done is a registered output:
  - done=1 for exactly one cycle after an edge where an instruction executed and no slot is pending after that edge, including same-edge captures.
  - Otherwise done=0. Starts with no execution never raise done.
- Back-to-back starts that keep the queue non-empty delay done until the queue drains.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> done=0, reg_out=0, mem_out=0 immediately. A subsequent LOAD of any addr returns 0.
- Single op: start1 with MOVI r3,0x25 at edge N -> at edge N+1 reg_out=0x25; done=1 in cycle N+1..N+2 only.
- Priority and sequencing:
  - same edge: start1 MOVI r1,200; start2 ADDI r2,r1,100; start3 SUB r4,r2,r1.
  - -> executes over 3 consecutive edges; reg_out = 200, then 44 (wraps), then 100 (44-200 mod 256).
  - done pulses once, after the third execution.
- Memory: STORE mem[0x80]=r1 (r1=0x5A), then LOAD r7,[0x80] -> mem_out=0x5A both times; reg_out=0x5A after the LOAD.
- Busy slot: start1 on two consecutive edges while slot 1 is still pending behind... (slot 1 always wins, so use port 3 behind ports 1 and 2) -> second start3 ignored; only the first inst3 executes.
- Reset mid-operation: three starts, then rst_n low after the first execution -> remaining two never execute and done stays 0.
